// File: rtl/ring_freq_counter.sv
// Gated rising-edge counter for the divided ring-oscillator output.
// Optional back-to-back measurement mode: define RING_FREQ_CONTINUOUS_EN.
module ring_freq_counter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   osc_prev;
  logic                   osc_rise;
  logic [GATE_W-1:0]      gate_cnt, gate_cnt_nxt;
  logic [CNT_W-1:0]       edge_cnt, edge_cnt_nxt;
  logic                   ovf_int, ovf_nxt;

  // osc_prev tracks the synchronizer every cycle, so by the time ARM has
  // elapsed it always holds the current level and no stale edge can count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      osc_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], osc_in};
      osc_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign osc_rise = sync_q[SYNC_STAGES-1] & ~osc_prev;

  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    edge_cnt_nxt = edge_cnt;
    ovf_nxt      = ovf_int;
    case (state)
      IDLE: begin
        if (start) begin
          edge_cnt_nxt = '0;
          ovf_nxt      = 1'b0;
          if (gate_cycles != '0) begin
            gate_cnt_nxt = gate_cycles;
            state_nxt    = ARM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ARM: begin
        edge_cnt_nxt = '0;
        ovf_nxt      = 1'b0;
        state_nxt    = GATE;
      end
      GATE: begin
        if (osc_rise && edge_cnt != CNT_MAX) begin
          edge_cnt_nxt = edge_cnt + CNT_ONE;
          if (edge_cnt == CNT_MAX - CNT_ONE) ovf_nxt = 1'b1;
        end
        gate_cnt_nxt = gate_cnt - GATE_ONE;
        if (gate_cnt == GATE_ONE) state_nxt = DONE;
      end
      DONE: begin
`ifdef RING_FREQ_CONTINUOUS_EN
        edge_cnt_nxt = '0;
        ovf_nxt      = 1'b0;
        if (gate_cycles != '0) begin
          gate_cnt_nxt = gate_cycles;
          state_nxt    = ARM;
        end else begin
          state_nxt = DONE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers load on the edge entering DONE so count is valid
  // in the same cycle done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_int  <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_cnt_nxt;
      edge_cnt <= edge_cnt_nxt;
      ovf_int  <= ovf_nxt;
      if (state_nxt == DONE) begin
        count    <= edge_cnt_nxt;
        overflow <= ovf_nxt;
      end
    end
  end

  assign busy = (state == ARM) || (state == GATE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ring_freq_counter.sv
// Scoreboard bench for ring_freq_counter: pregenerated osc waveform, edge-count model.
module tb_ring_freq_counter;
  localparam int CNT_W  = 4;
  localparam int GATE_W = 8;
  localparam int SS     = 2;
  localparam int MAXC   = 20000;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              osc_in;
  logic              start;
  logic [GATE_W-1:0] gate_cycles;
  logic              busy, done, overflow;
  logic [CNT_W-1:0]  count;

  ring_freq_counter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .gate_cycles(gate_cycles),
    .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int cnt; bit ovf;} exp_t;
  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  bit   w[MAXC];
  int   last_cnt = 0;
  bit   last_ovf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // waveform value w[c] is driven during cycle c
  initial begin
    osc_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      osc_in = (cyc < MAXC) ? w[cyc] : 1'b0;
    end
  end

  // Rising edges of the osc waveform as seen through SS sync flops, inside the gate window.
  function automatic void model(input int c0, input int n, output int cnt, output bit ovf);
    int e = 0;
    for (int c = c0 + 2; c <= c0 + 1 + n; c++)
      if (w[c-SS] && !w[c-SS-1]) e++;
    ovf = (e >= SAT);
    cnt = ovf ? SAT : e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic set_wave(input int from, input int len, input int half);
    for (int k = 0; k < len; k++)
      if (from + k < MAXC) w[from+k] = ((k / half) % 2) == 1;
  endtask

  task automatic issue(input int n, input bit expect_resp);
    exp_t e;
    @(posedge clk); #1;
    start       = 1'b1;
    gate_cycles = n[GATE_W-1:0];
    e.cyc = cyc + ((n == 0) ? 1 : n + 2);
    model(cyc, n, e.cnt, e.ovf);
    if (expect_resp) exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
`ifndef RING_FREQ_CONTINUOUS_EN
    gate_cycles = GATE_W'($urandom);
`endif
  endtask

  task automatic wait_idle(input int budget);
    int b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout pending=%0d (cycle %0d)", exp_q.size(), cyc);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(name, done, 0);
    end
  endtask

  // monitor: every done pulse must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done count=%0d (cycle %0d)", count, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          checks++;
          if (count != e.cnt || overflow != e.ovf || busy) begin
            errors++;
            $display("FAIL result count=%0d ovf=%0b busy=%0b expected count=%0d ovf=%0b busy=0",
                     count, overflow, busy, e.cnt, e.ovf);
          end
          last_cnt = e.cnt;
          last_ovf = e.ovf;
        end
      end
    end
  end

  initial begin
    int k = 0;
    while (k < MAXC) begin
      int len = $urandom_range(200, 20);
      int h   = $urandom_range(7, 2);
      bit cst = ($urandom_range(5, 0) == 0);
      bit lvl = 1'($urandom_range(1, 0));
      for (int j = 0; j < len; j++) begin
        if (k < MAXC) w[k] = cst ? lvl : (((j / h) % 2) == 1);
        k++;
      end
    end

    rst = 1'b1; start = 1'b0; gate_cycles = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    idle_cycles("idle_no_done", 20);

`ifdef RING_FREQ_CONTINUOUS_EN
    begin
      exp_t e;
      int c0;
      set_wave(cyc + 3, 400, 5);
      repeat (6) @(posedge clk);
      #1;
      start = 1'b1; gate_cycles = 8'd20; c0 = cyc;
      for (int i = 0; i < 6; i++) begin
        e.cyc = c0 + (i + 1) * 22;
        model(c0 + i * 22, 20, e.cnt, e.ovf);
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("cont_busy_arm", busy, 1);
      wait_idle(400);
      chk("cont_count", count, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("cont_rst_busy", busy, 0);
      chk("cont_rst_count", count, 0);
      idle_cycles("cont_stopped", 40);
    end
`else
    // basic: period 10, gate 100 -> 10 edges
    set_wave(cyc + 3, 300, 5);
    repeat (6) @(posedge clk);
    issue(100, 1);
    wait_idle(300);
    chk("basic_count", count, 10);
    chk("basic_ovf", overflow, 0);
    repeat (15) @(posedge clk);
    #1;
    chk("basic_held", count, 10);

    // zero gate: done next cycle, never busy
    issue(0, 1);
    chk("zero_busy", busy, 0);
    chk("zero_done_next", done, 1);
    @(posedge clk); #1;
    chk("zero_busy_after", busy, 0);
    wait_idle(20);
    chk("zero_count", count, 0);

    // saturation: period 4, gate 80 -> 20 edges, then gate 8 -> 2 edges
    set_wave(cyc + 3, 300, 2);
    repeat (6) @(posedge clk);
    issue(80, 1);
    wait_idle(300);
    chk("sat_count", count, SAT);
    chk("sat_ovf", overflow, 1);
    issue(8, 1);
    wait_idle(100);
    chk("small_count", count, 2);
    chk("small_ovf", overflow, 0);

    // start while busy is ignored
    set_wave(cyc + 3, 300, 5);
    repeat (6) @(posedge clk);
    issue(100, 1);
    repeat (49) begin @(posedge clk); #1; end
    start = 1'b1; gate_cycles = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(300);
    chk("ignored_count", count, 10);

    // saturating run, then reset at GATE cycle 30 of a new run
    set_wave(cyc + 3, 300, 2);
    repeat (6) @(posedge clk);
    issue(80, 1);
    wait_idle(300);
    chk("pre_rst_ovf", overflow, 1);
    issue(100, 0);
    repeat (30) begin @(posedge clk); #1; end
    chk("mid_gate_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 0);
    chk("abort_ovf", overflow, 0);
    last_cnt = 0; last_ovf = 0;
    idle_cycles("abort_no_done", 110);

    // randomized runs over the pregenerated waveform, with stray starts while busy
    for (int r = 0; r < 30; r++) begin
      int n = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(90, 1);
      issue(n, 1);
      if (n > 0 && $urandom_range(1, 0) == 1) begin
        int kk = $urandom_range(n, 0);
        repeat (kk) begin @(posedge clk); #1; end
        start = 1'b1; gate_cycles = GATE_W'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_idle(300);
      repeat ($urandom_range(4, 0)) @(posedge clk);
      #1;
      chk("rand_held_count", count, last_cnt);
      chk("rand_held_ovf", overflow, last_ovf);
    end
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
